// File: rtl/jtag_mailbox_sys_side.sv
// jtag_mailbox_sys_side
//   System-clock side of the JTAG mailbox. It terminates the toggle handshakes
//   driven by the JTAG data-register block:
//     - Inbound JTAG requests are buffered in a request FIFO and offered to the
//       system as a valid/ready stream.
//     - System responses are buffered in a response FIFO and published to the
//       JTAG side one word at a time. The word is loaded first and the toggle
//       moves one cycle later.
//     - Occupancy counts are exported for the JTAG NUM_REQUEST/NUM_RESPONSE reads.
//
// Ports
//   clk, rstnn            system clock, asynchronous active-low reset
//   jtag_req_toggle       async, flips once per new JTAG request
//   jtag_req_data         async, stable while a request toggle is pending
//   jtag_req_ack_toggle   last accepted jtag_req_toggle value
//   num_request           request FIFO occupancy, zero-extended
//   jtag_rsp_toggle       flips once per published response
//   jtag_rsp_data         published response word
//   jtag_rsp_ack_toggle   async, JTAG copy of jtag_rsp_toggle once consumed
//   num_response          response FIFO occupancy plus the outstanding word
//   sys_req_valid/data/ready   request stream towards the system
//   sys_rsp_valid/data/ready   response stream from the system
module jtag_mailbox_sys_side #(
  parameter int unsigned BW_DATA   = 32,
  parameter int unsigned DEPTH_REQ = 4,
  parameter int unsigned DEPTH_RSP = 4,
  parameter int unsigned BW_COUNT  = 32
) (
  input  logic                clk,
  input  logic                rstnn,
  input  logic                jtag_req_toggle,
  input  logic [BW_DATA-1:0]  jtag_req_data,
  output logic                jtag_req_ack_toggle,
  output logic [BW_COUNT-1:0] num_request,
  output logic                jtag_rsp_toggle,
  output logic [BW_DATA-1:0]  jtag_rsp_data,
  input  logic                jtag_rsp_ack_toggle,
  output logic [BW_COUNT-1:0] num_response,
  output logic                sys_req_valid,
  output logic [BW_DATA-1:0]  sys_req_data,
  input  logic                sys_req_ready,
  input  logic                sys_rsp_valid,
  input  logic [BW_DATA-1:0]  sys_rsp_data,
  output logic                sys_rsp_ready
);

  localparam int unsigned AW_REQ = $clog2(DEPTH_REQ);
  localparam int unsigned AW_RSP = $clog2(DEPTH_RSP);
  localparam logic [AW_REQ:0] REQ_FULL_COUNT = DEPTH_REQ[AW_REQ:0];
  localparam logic [AW_RSP:0] RSP_FULL_COUNT = DEPTH_RSP[AW_RSP:0];

  typedef enum logic [1:0] {
    PUB_IDLE,
    PUB_LOAD,
    PUB_WAIT_ACK
  } pub_state_t;

  // ---------------------------------------------------------------------------
  // Toggle synchronizers
  // ---------------------------------------------------------------------------
  logic req_sync1, req_sync2;
  logic ack_sync1, ack_sync2;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      req_sync1 <= 1'b0;
      req_sync2 <= 1'b0;
      ack_sync1 <= 1'b0;
      ack_sync2 <= 1'b0;
    end else begin
      req_sync1 <= jtag_req_toggle;
      req_sync2 <= req_sync1;
      ack_sync1 <= jtag_rsp_ack_toggle;
      ack_sync2 <= ack_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [BW_DATA-1:0] req_mem [DEPTH_REQ];
  logic [AW_REQ-1:0]  req_wr_ptr, req_rd_ptr;
  logic [AW_REQ:0]    req_count;
  logic               req_full, req_empty, req_pending, req_push, req_pop;

  assign req_full    = (req_count == REQ_FULL_COUNT);
  assign req_empty   = (req_count == '0);
  assign req_pending = (req_sync2 != jtag_req_ack_toggle);
  assign req_pop     = sys_req_valid & sys_req_ready;
  // A full FIFO still accepts when the head leaves in the same cycle; otherwise
  // the ack is withheld so the JTAG side sees busy and nothing is dropped.
  assign req_push    = req_pending & (~req_full | req_pop);

  assign sys_req_valid = ~req_empty;
  assign sys_req_data  = req_mem[req_rd_ptr];
  assign num_request   = BW_COUNT'(req_count);

  always_ff @(posedge clk) begin
    if (req_push) req_mem[req_wr_ptr] <= jtag_req_data;
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      req_wr_ptr          <= '0;
      req_rd_ptr          <= '0;
      req_count           <= '0;
      jtag_req_ack_toggle <= 1'b0;
    end else begin
      if (req_push) begin
        req_wr_ptr          <= req_wr_ptr + AW_REQ'(1);
        jtag_req_ack_toggle <= req_sync2;
      end
      if (req_pop) req_rd_ptr <= req_rd_ptr + AW_REQ'(1);
      if (req_push && !req_pop)      req_count <= req_count + (AW_REQ+1)'(1);
      else if (!req_push && req_pop) req_count <= req_count - (AW_REQ+1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  logic [BW_DATA-1:0] rsp_mem [DEPTH_RSP];
  logic [AW_RSP-1:0]  rsp_wr_ptr, rsp_rd_ptr;
  logic [AW_RSP:0]    rsp_count;
  logic               rsp_empty, rsp_push, rsp_pop;

  assign rsp_empty     = (rsp_count == '0);
  assign sys_rsp_ready = (rsp_count != RSP_FULL_COUNT);
  assign rsp_push      = sys_rsp_valid & sys_rsp_ready;

  always_ff @(posedge clk) begin
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= sys_rsp_data;
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + AW_RSP'(1);
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + AW_RSP'(1);
      if (rsp_push && !rsp_pop)      rsp_count <= rsp_count + (AW_RSP+1)'(1);
      else if (!rsp_push && rsp_pop) rsp_count <= rsp_count - (AW_RSP+1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Publish FSM: data-then-toggle, one word outstanding at a time
  // ---------------------------------------------------------------------------
  pub_state_t pub_state, pub_next;
  logic       rsp_toggle_flip;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) pub_state <= PUB_IDLE;
    else        pub_state <= pub_next;
  end

  always_comb begin
    pub_next        = pub_state;
    rsp_pop         = 1'b0;
    rsp_toggle_flip = 1'b0;
    unique case (pub_state)
      PUB_IDLE: begin
        if (!rsp_empty) begin
          rsp_pop  = 1'b1;
          pub_next = PUB_LOAD;
        end
      end
      PUB_LOAD: begin
        rsp_toggle_flip = 1'b1;
        pub_next        = PUB_WAIT_ACK;
      end
      PUB_WAIT_ACK: begin
        if (ack_sync2 == jtag_rsp_toggle) pub_next = PUB_IDLE;
      end
      default: pub_next = PUB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      jtag_rsp_data   <= '0;
      jtag_rsp_toggle <= 1'b0;
    end else begin
      if (rsp_pop)         jtag_rsp_data   <= rsp_mem[rsp_rd_ptr];
      if (rsp_toggle_flip) jtag_rsp_toggle <= ~jtag_rsp_toggle;
    end
  end

  // The popped word stays counted until the JTAG side acknowledges it.
  assign num_response = BW_COUNT'(rsp_count) + BW_COUNT'(pub_state != PUB_IDLE);

endmodule

// File: tb/tb_jtag_mailbox_sys_side.sv
module tb_jtag_mailbox_sys_side;

  localparam int unsigned BW_DATA   = 32;
  localparam int unsigned DEPTH_REQ = 4;
  localparam int unsigned DEPTH_RSP = 4;
  localparam int unsigned BW_COUNT  = 32;

  logic                clk = 1'b0;
  logic                rstnn;
  logic                jtag_req_toggle = 1'b0;
  logic [BW_DATA-1:0]  jtag_req_data = '0;
  logic                jtag_req_ack_toggle;
  logic [BW_COUNT-1:0] num_request;
  logic                jtag_rsp_toggle;
  logic [BW_DATA-1:0]  jtag_rsp_data;
  logic                jtag_rsp_ack_toggle = 1'b0;
  logic [BW_COUNT-1:0] num_response;
  logic                sys_req_valid;
  logic [BW_DATA-1:0]  sys_req_data;
  logic                sys_req_ready = 1'b0;
  logic                sys_rsp_valid = 1'b0;
  logic [BW_DATA-1:0]  sys_rsp_data = '0;
  logic                sys_rsp_ready;

  jtag_mailbox_sys_side #(
    .BW_DATA  (BW_DATA),
    .DEPTH_REQ(DEPTH_REQ),
    .DEPTH_RSP(DEPTH_RSP),
    .BW_COUNT (BW_COUNT)
  ) dut (
    .clk                (clk),
    .rstnn              (rstnn),
    .jtag_req_toggle    (jtag_req_toggle),
    .jtag_req_data      (jtag_req_data),
    .jtag_req_ack_toggle(jtag_req_ack_toggle),
    .num_request        (num_request),
    .jtag_rsp_toggle    (jtag_rsp_toggle),
    .jtag_rsp_data      (jtag_rsp_data),
    .jtag_rsp_ack_toggle(jtag_rsp_ack_toggle),
    .num_response       (num_response),
    .sys_req_valid      (sys_req_valid),
    .sys_req_data       (sys_req_data),
    .sys_req_ready      (sys_req_ready),
    .sys_rsp_valid      (sys_rsp_valid),
    .sys_rsp_data       (sys_rsp_data),
    .sys_rsp_ready      (sys_rsp_ready)
  );

  always #5 clk = ~clk;

  // Scoreboard state
  int unsigned        n_pass = 0;
  int unsigned        n_total = 0;
  logic [BW_DATA-1:0] req_q[$];
  logic [BW_DATA-1:0] rsp_q[$];
  bit                 mon_en = 1'b0;
  int unsigned        epoch = 0;
  int unsigned        pop_pct = 0;
  int unsigned        pop_credit = 0;
  bit                 rsp_ack_free = 1'b0;
  int unsigned        rsp_ack_credit = 0;
  int unsigned        pub_count = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Request consumer/monitor: occupancy model is (#requests acked) - (#popped).
  initial begin
    int unsigned ep = 0;
    logic last_ack = 1'b0;
    int unsigned acked = 0;
    int unsigned popped = 0;
    logic [BW_DATA-1:0] exp;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        sys_req_ready = 1'b0;
        continue;
      end
      if (ep != epoch) begin
        ep = epoch; last_ack = 1'b0; acked = 0; popped = 0;
      end
      if (jtag_req_ack_toggle != last_ack) begin
        last_ack = jtag_req_ack_toggle;
        acked++;
      end
      check(num_request == BW_COUNT'(acked - popped), "num_request", num_request, acked - popped);
      check(sys_req_valid == (acked > popped), "sys_req_valid", sys_req_valid, acked > popped);
      sys_req_ready = (pop_credit > 0) || ($urandom_range(99) < pop_pct);
      if (sys_req_valid && sys_req_ready) begin
        if (pop_credit > 0) pop_credit--;
        popped++;
        if (req_q.size() == 0) check(1'b0, "req_unexpected", sys_req_data, 0);
        else begin
          exp = req_q.pop_front();
          check(sys_req_data == exp, "sys_req_data", sys_req_data, exp);
        end
      end
    end
  end

  // JTAG response consumer: detects each publish, checks order and setup, acks.
  initial begin
    int unsigned ep = 0;
    logic seen = 1'b0;
    logic [BW_DATA-1:0] prev = '0;
    logic [BW_DATA-1:0] exp;
    forever begin
      @(negedge clk);
      if (ep != epoch) begin
        ep = epoch; seen = 1'b0;
      end
      if (rstnn && jtag_rsp_toggle != seen) begin
        seen = jtag_rsp_toggle;
        pub_count++;
        check(prev == jtag_rsp_data, "rsp_data_setup", prev, jtag_rsp_data);
        if (rsp_q.size() == 0) check(1'b0, "rsp_unexpected", jtag_rsp_data, 0);
        else begin
          exp = rsp_q.pop_front();
          check(jtag_rsp_data == exp, "jtag_rsp_data", jtag_rsp_data, exp);
        end
        repeat ($urandom_range(3)) @(negedge clk);
        while (!(rsp_ack_free || rsp_ack_credit > 0) && ep == epoch) @(negedge clk);
        if (ep == epoch) begin
          if (!rsp_ack_free) rsp_ack_credit--;
          jtag_rsp_ack_toggle = seen;
        end
      end
      prev = jtag_rsp_data;
    end
  end

  task automatic jtag_wait_ack(input string name);
    int unsigned n = 0;
    while (jtag_req_ack_toggle != jtag_req_toggle && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(jtag_req_ack_toggle == jtag_req_toggle, name, jtag_req_ack_toggle, jtag_req_toggle);
  endtask

  task automatic jtag_flip(input logic [BW_DATA-1:0] d);
    jtag_req_data   = d;
    jtag_req_toggle = ~jtag_req_toggle;
    req_q.push_back(d);
  endtask

  task automatic jtag_send(input logic [BW_DATA-1:0] d);
    jtag_wait_ack("req_ack_wait");
    jtag_flip(d);
  endtask

  task automatic rsp_push(input logic [BW_DATA-1:0] d);
    int unsigned n = 0;
    @(negedge clk);
    sys_rsp_valid = 1'b1;
    sys_rsp_data  = d;
    while (!sys_rsp_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!sys_rsp_ready) check(1'b0, "rsp_push_timeout", 0, 1);
    else rsp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_num_rsp(input int unsigned exp, input string name);
    int unsigned n = 0;
    while (num_response != BW_COUNT'(exp) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(num_response == BW_COUNT'(exp), name, num_response, exp);
  endtask

  task automatic wait_pub(input int unsigned target, input string name);
    int unsigned n = 0;
    while (pub_count < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(pub_count == target, name, pub_count, target);
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while ((req_q.size() != 0 || rsp_q.size() != 0 || num_response != 0 || num_request != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(req_q.size() == 0 && rsp_q.size() == 0 && num_response == 0 && num_request == 0,
          name, {req_q.size(), rsp_q.size()}, 0);
  endtask

  initial begin
    int unsigned base;
    rstnn = 1'b1;
    #1 rstnn = 1'b0;
    #2;
    check(jtag_req_ack_toggle == 1'b0, "rst_req_ack", jtag_req_ack_toggle, 0);
    check(jtag_rsp_toggle == 1'b0, "rst_rsp_toggle", jtag_rsp_toggle, 0);
    check(jtag_rsp_data == '0, "rst_rsp_data", jtag_rsp_data, 0);
    check(num_request == '0, "rst_num_request", num_request, 0);
    check(num_response == '0, "rst_num_response", num_response, 0);
    check(sys_req_valid == 1'b0, "rst_req_valid", sys_req_valid, 0);
    check(sys_rsp_ready == 1'b1, "rst_rsp_ready", sys_rsp_ready, 1);
    repeat (3) @(posedge clk);
    #2 rstnn = 1'b1;
    mon_en = 1'b1;

    // Single request: three edges from toggle to push.
    @(posedge clk); #2;
    jtag_flip(32'hDEADBEEF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check(jtag_req_ack_toggle == 1'b0, "req_ack_early", jtag_req_ack_toggle, 0);
    @(posedge clk); #1;
    check(jtag_req_ack_toggle == 1'b1, "req_ack_3rd_edge", jtag_req_ack_toggle, 1);
    check(num_request == 1, "req_count_1", num_request, 1);
    check(sys_req_data == 32'hDEADBEEF, "req_head", sys_req_data, 32'hDEADBEEF);
    pop_credit = 1;
    repeat (2) @(posedge clk); #1;
    check(num_request == 0, "req_count_after_pop", num_request, 0);

    // Fill the request FIFO; fifth request must stall, then go in with a pop.
    for (int i = 0; i < 4; i++) jtag_send(32'h1000_0000 + i);
    jtag_wait_ack("req_ack_4th");
    jtag_flip(32'h1000_0004);
    repeat (8) @(posedge clk); #1;
    check(jtag_req_ack_toggle != jtag_req_toggle, "req_ack_held", jtag_req_ack_toggle, ~jtag_req_toggle);
    check(num_request == 4, "req_count_full", num_request, 4);
    pop_credit = 1;
    @(posedge clk); #1;
    check(jtag_req_ack_toggle == jtag_req_toggle, "req_5th_acked", jtag_req_ack_toggle, jtag_req_toggle);
    check(num_request == 4, "req_count_pop_push", num_request, 4);
    pop_pct = 100;
    drain("drain_req");

    // Single response publish with held ack.
    rsp_ack_free = 1'b0; rsp_ack_credit = 0;
    base = pub_count;
    rsp_push(32'h12345678);
    sys_rsp_valid = 1'b0;
    wait_pub(base + 1, "rsp_publish_1");
    check(num_response == 1, "rsp_count_outstanding", num_response, 1);
    rsp_ack_credit = 1;
    wait_num_rsp(0, "rsp_count_acked");

    // Three back-to-back responses, released one ack at a time.
    base = pub_count;
    rsp_push(32'hA); rsp_push(32'hB); rsp_push(32'hC);
    sys_rsp_valid = 1'b0;
    repeat (10) @(negedge clk);
    check(pub_count == base + 1, "rsp_only_one_out", pub_count, base + 1);
    check(num_response == 3, "rsp_count_3", num_response, 3);
    rsp_ack_credit = 1;
    wait_num_rsp(2, "rsp_count_2");
    wait_pub(base + 2, "rsp_publish_b");
    rsp_ack_credit = 1;
    wait_num_rsp(1, "rsp_count_1");
    wait_pub(base + 3, "rsp_publish_c");
    rsp_ack_credit = 1;
    wait_num_rsp(0, "rsp_count_0");

    // Random concurrent traffic on both directions.
    pop_pct = 60;
    rsp_ack_free = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(3)) @(posedge clk);
          #2;
          jtag_send($urandom);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(1) == 1) begin
            sys_rsp_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
          end
          rsp_push($urandom);
        end
        sys_rsp_valid = 1'b0;
      end
    join
    drain("drain_random");

    // Reset while publishing with both FIFOs holding data.
    rsp_ack_free = 1'b0; rsp_ack_credit = 0; pop_pct = 0;
    base = pub_count;
    for (int i = 0; i < 5; i++) rsp_push(32'hC0DE_0000 + i);
    @(negedge clk);
    sys_rsp_valid = 1'b1;
    sys_rsp_data  = 32'hBAD0BAD0;
    repeat (4) @(negedge clk);
    check(sys_rsp_ready == 1'b0, "rsp_ready_full", sys_rsp_ready, 0);
    check(num_response == 5, "rsp_count_full", num_response, 5);
    check(pub_count == base + 1, "rsp_one_outstanding", pub_count, base + 1);
    jtag_send(32'h7777_0001);
    jtag_send(32'h7777_0002);
    jtag_wait_ack("req_ack_pre_reset");
    @(posedge clk); #2;
    rstnn = 1'b0;
    mon_en = 1'b0;
    epoch++;
    jtag_req_toggle = 1'b0;
    jtag_rsp_ack_toggle = 1'b0;
    sys_rsp_valid = 1'b0;
    req_q.delete();
    rsp_q.delete();
    #1;
    check(jtag_req_ack_toggle == 1'b0, "rst2_req_ack", jtag_req_ack_toggle, 0);
    check(jtag_rsp_toggle == 1'b0, "rst2_rsp_toggle", jtag_rsp_toggle, 0);
    check(jtag_rsp_data == '0, "rst2_rsp_data", jtag_rsp_data, 0);
    check(num_request == '0, "rst2_num_request", num_request, 0);
    check(num_response == '0, "rst2_num_response", num_response, 0);
    check(sys_req_valid == 1'b0, "rst2_req_valid", sys_req_valid, 0);
    check(sys_rsp_ready == 1'b1, "rst2_rsp_ready", sys_rsp_ready, 1);
    repeat (3) @(posedge clk);
    #2 rstnn = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(posedge clk); #1;
    check(jtag_rsp_toggle == 1'b0, "no_stale_publish", jtag_rsp_toggle, 0);
    check(num_response == '0, "post_rst_num_response", num_response, 0);
    check(pub_count == base + 1, "post_rst_pub_count", pub_count, base + 1);
    check(jtag_req_ack_toggle == 1'b0, "post_rst_req_ack", jtag_req_ack_toggle, 0);

    // Traffic still flows after reset.
    rsp_ack_free = 1'b1;
    pop_pct = 100;
    jtag_send(32'h600D_F00D);
    rsp_push(32'h5A5A_A5A5);
    sys_rsp_valid = 1'b0;
    drain("drain_post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_total);
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule
